// File: rtl/disp_pkg.sv
// disp_pkg: shared seven-segment types, digit count and hex glyph table for the display bus
package disp_pkg;
  typedef logic [6:0] seg7_t;
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} an_state_e;
  localparam int NUM_DIGITS = 4;
  // Glyphs are {g,f,e,d,c,b,a}, active-high, indexed by hex value 0-F
  localparam seg7_t SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [1:0] onehot_idx(input logic [3:0] an);
    return {an[3] | an[2], an[3] | an[1]};
  endfunction
endpackage

// File: rtl/anodo_scan_capture_seg7_to_hex.sv
// seg7_to_hex: reverse lookup of a seven-segment glyph into its hex nibble plus a legality flag
module seg7_to_hex
  import disp_pkg::*;
(
  input  seg7_t      glyph,
  output logic [3:0] nibble,
  output logic       valid
);
  // Scan the glyph table; unknown patterns decode to 0 with valid low
  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    for (int k = 0; k < 16; k++)
      if (glyph == SEG_GLYPH[k]) begin
        nibble = 4'(k);
        valid  = 1'b1;
      end
  end
endmodule

// File: rtl/anodo_scan_capture.sv
// anodo_scan_capture: rebuilds 4-digit frames from a multiplexed anode/segment bus (optional decode: SEG2HEX_DECODE_EN)
module anodo_scan_capture
  import disp_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [3:0]                  AN,
  input  logic [6:0]                  SEG,
  input  logic                        err_clr,
  output seg7_t [NUM_DIGITS-1:0]      digit_seg,
  output logic                        frame_done,
  output logic                        err_onehot,
  output logic                        stale,
  output logic [4*NUM_DIGITS-1:0]     hex,
  output logic [NUM_DIGITS-1:0]       hex_valid
);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [3:0] an_q, ref_an, seen;
  seg7_t seg_q, ref_seg;
  seg7_t [NUM_DIGITS-1:0] staging;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  an_state_e state;
  logic one_hot, multi, match, restart, capture, full;
  assign one_hot = an_q != 4'h0 && (an_q & (an_q - 4'h1)) == 4'h0;
  assign multi   = an_q != 4'h0 && !one_hot;
  assign match   = an_q == ref_an && seg_q == ref_seg;
  // Idle, or any change of the sampled bus, is handled as a fresh look at the inputs
  assign restart = state == IDLE || !match;
  assign capture = restart ? (one_hot && SETTLE_CYC == 1)
                           : (state == SETTLE && int'(cnt) + 1 == SETTLE_CYC);
  assign full    = seen == 4'hF;
  assign stale   = tcnt == TW'(TIMEOUT_CYC);
  // Register the raw bus once so every decision sees a single consistent sample
  always_ff @(posedge clk)
    if (!reset_n) begin
      an_q  <= 4'h0;
      seg_q <= '0;
    end else begin
      an_q  <= AN;
      seg_q <= SEG;
    end
  // Settle FSM: count stable cycles of one (anode, segment) pair before capturing it
  always_ff @(posedge clk)
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ref_an  <= 4'h0;
      ref_seg <= '0;
    end else if (restart) begin
      ref_an  <= an_q;
      ref_seg <= seg_q;
      cnt     <= CW'(1);
      state   <= !one_hot ? IDLE : capture ? CAPTURED : SETTLE;
    end else if (state == SETTLE) begin
      cnt   <= cnt + CW'(1);
      state <= capture ? CAPTURED : SETTLE;
    end
  // Staging and frame assembly; a capture on the publish edge starts the next frame
  always_ff @(posedge clk)
    if (!reset_n) begin
      staging    <= '0;
      seen       <= 4'h0;
      digit_seg  <= '0;
      frame_done <= 1'b0;
    end else begin
      if (capture) staging[onehot_idx(an_q)] <= seg_q;
      seen       <= (full ? 4'h0 : seen) | (capture ? an_q : 4'h0);
      frame_done <= full;
      if (full) digit_seg <= staging;
    end
  // Stale timer restarts on the publish edge so stale drops with frame_done; error flag is set-dominant
  always_ff @(posedge clk)
    if (!reset_n) begin
      tcnt       <= '0;
      err_onehot <= 1'b0;
    end else begin
      tcnt       <= full ? '0 : stale ? tcnt : tcnt + TW'(1);
      err_onehot <= multi | (err_onehot & !err_clr);
    end
`ifdef SEG2HEX_DECODE_EN
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg7_to_hex u_dec (
      .glyph  (digit_seg[i]),
      .nibble (hex[4*i +: 4]),
      .valid  (hex_valid[i])
    );
  end
`else
  assign hex       = '0;
  assign hex_valid = '0;
`endif
endmodule

// File: tb/tb_anodo_scan_capture.sv
// tb_anodo_scan_capture: directed self-checking bench for the display bus capture block
module tb_anodo_scan_capture;
  logic clk = 1'b0;
  logic reset_n, err_clr, frame_done, err_onehot, stale;
  logic [3:0] AN, hex_valid;
  logic [6:0] SEG;
  logic [3:0][6:0] digit_seg;
  logic [15:0] hex;
  int checks = 0, errors = 0, fd_seen = 0, fd_base = 0;
  logic fd_stale;
  logic [6:0] gl [16];

  always #5 clk = ~clk;

  anodo_scan_capture #(.SETTLE_CYC(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset_n(reset_n), .AN(AN), .SEG(SEG), .err_clr(err_clr),
    .digit_seg(digit_seg), .frame_done(frame_done), .err_onehot(err_onehot),
    .stale(stale), .hex(hex), .hex_valid(hex_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        fd_seen++;
        fd_stale = stale;
      end
    end
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] s, input int n);
    AN  = an;
    SEG = s;
    step(n);
  endtask

  task automatic chk_hex(input string tag, input logic [15:0] h, input logic [3:0] v);
`ifdef SEG2HEX_DECODE_EN
    chk({tag, "_hex"}, 32'(hex), 32'(h));
    chk({tag, "_valid"}, 32'(hex_valid), 32'(v));
`else
    chk({tag, "_hex"}, 32'(hex), 32'h0);
    chk({tag, "_valid"}, 32'(hex_valid), 32'h0);
`endif
  endtask

  initial begin
    gl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    reset_n = 1'b0; AN = 4'h0; SEG = 7'h0; err_clr = 1'b0; fd_stale = 1'b1;
    step(3);
    chk("rst_digits", 32'(digit_seg), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_err", 32'(err_onehot), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    chk_hex("rst", 16'h0, 4'h0);
    reset_n = 1'b1;
    step(60);
    chk("stale_early", 32'(stale), 32'h0);
    step(10);
    chk("stale_set", 32'(stale), 32'h1);
    fd_base = fd_seen;
    show(4'b0001, gl[1], 8); show(4'b0010, gl[2], 8);
    show(4'b0100, gl[3], 8); show(4'b1000, gl[4], 8);
    chk("sweep_frames", 32'(fd_seen - fd_base), 32'h1);
    chk("sweep_stale_at_fd", 32'(fd_stale), 32'h0);
    chk("sweep_stale_after", 32'(stale), 32'h0);
    chk("sweep_digits", 32'(digit_seg), {4'h0, gl[4], gl[3], gl[2], gl[1]});
    chk_hex("sweep", 16'h4321, 4'hF);
    show(4'h0, 7'h0, 2);
    fd_base = fd_seen;
    show(4'b0001, gl[5], 2); show(4'b0001, gl[6], 3);
    show(4'b0010, gl[2], 8); show(4'b0100, gl[3], 8); show(4'b1000, gl[4], 8);
    chk("glitch_no_frame", 32'(fd_seen - fd_base), 32'h0);
    show(4'b0001, gl[7], 2); show(4'b0001, gl[6], 8);
    chk("glitch_frame", 32'(fd_seen - fd_base), 32'h1);
    chk("glitch_digits", 32'(digit_seg), {4'h0, gl[4], gl[3], gl[2], gl[6]});
    chk_hex("glitch", 16'h4326, 4'hF);
    show(4'b0011, 7'h0, 1); show(4'h0, 7'h0, 3);
    chk("err_set", 32'(err_onehot), 32'h1);
    step(3);
    chk("err_sticky", 32'(err_onehot), 32'h1);
    err_clr = 1'b1; step(1); err_clr = 1'b0; step(1);
    chk("err_cleared", 32'(err_onehot), 32'h0);
    show(4'b1100, 7'h0, 1);
    err_clr = 1'b1; step(1); err_clr = 1'b0; AN = 4'h0; step(1);
    chk("err_set_wins", 32'(err_onehot), 32'h1);
    err_clr = 1'b1; step(1); err_clr = 1'b0; step(2);
    chk("err_cleared2", 32'(err_onehot), 32'h0);
    show(4'b0001, gl[9], 8); show(4'b0010, gl[10], 8); show(4'b0100, gl[11], 8);
    reset_n = 1'b0;
    step(1);
    chk("midrst_digits", 32'(digit_seg), 32'h0);
    chk("midrst_frame_done", 32'(frame_done), 32'h0);
    chk("midrst_stale", 32'(stale), 32'h0);
    chk_hex("midrst", 16'h0, 4'h0);
    reset_n = 1'b1;
    fd_base = fd_seen;
    show(4'b1000, gl[12], 8);
    chk("midrst_no_frame", 32'(fd_seen - fd_base), 32'h0);
    show(4'b0001, gl[9], 8); show(4'b0010, gl[10], 8);
    show(4'b0100, gl[11], 8); show(4'b1000, gl[12], 8);
    chk("midrst_frame", 32'(fd_seen - fd_base), 32'h1);
    chk("midrst_new_digits", 32'(digit_seg), {4'h0, gl[12], gl[11], gl[10], gl[9]});
    chk_hex("midrst_new", 16'hCBA9, 4'hF);
    show(4'h0, 7'h0, 2);
    fd_base = fd_seen;
    show(4'b1000, gl[15], 8); show(4'b0001, gl[0], 8);
    show(4'b0010, gl[1], 8); show(4'b0100, 7'h49, 8);
    chk("illegal_frame", 32'(fd_seen - fd_base), 32'h1);
    chk("illegal_digits", 32'(digit_seg), {4'h0, gl[15], 7'h49, gl[1], gl[0]});
    chk_hex("illegal", 16'hF010, 4'b1011);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
